// File: rtl/rand_sched_pkg.sv
// Shared definitions for the random-number scheduler: sample width default,
// FSM state encoding and the fallback value returned after too many rejects.
package rand_sched_pkg;

    localparam int unsigned RndW = 5;

    localparam int unsigned FallbackVal = 0;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSample = 2'd1,
        StDone   = 2'd2
    } state_e;

endpackage

// File: rtl/rand_sched_if.sv
// Request/response bundle between game consumers (master) and the scheduler (slave).
interface rand_sched_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned RND_W = 5
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*RND_W-1:0] lim;
    logic [N_REQ-1:0]       gnt;
    logic                   rsp_valid;
    logic [RND_W-1:0]       rsp_data;
    logic                   rsp_fb;
    logic                   busy;

    modport master (
        output req, lim,
        input  gnt, rsp_valid, rsp_data, rsp_fb, busy
    );

    modport slave (
        input  req, lim,
        output gnt, rsp_valid, rsp_data, rsp_fb, busy
    );
endinterface

// File: rtl/rand_sched_rr_pick.sv
// Combinational round-robin picker: rotate so rr_ptr+1 is bit 0, take the
// lowest set bit, then rotate the index back.
module rand_sched_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IdxW-1:0]  rr_ptr,
    output logic             any,
    output logic [IdxW-1:0]  winner
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    int unsigned        start;
    int unsigned        pos;
    int unsigned        sum;

    always_comb begin
        start = (32'(rr_ptr) + 32'd1) % N_REQ;
        dbl   = {req, req};
        rot   = N_REQ'(dbl >> start);
        any   = |rot;
        pos   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = unsigned'(i);
        end
        sum    = (pos + start) % N_REQ;
        winner = IdxW'(sum);
    end
endmodule

// File: rtl/rand_sched.sv
// Round-robin scheduler that hands out one range-limited sample of the shared
// free-running generator per grant, using rejection sampling with a fallback.
module rand_sched
    import rand_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned RND_W   = RndW,
    parameter int unsigned MAX_TRY = 8
) (
    input logic             clk,
    input logic             rst,
    input logic [RND_W-1:0] rnd_in,
    rand_sched_if.slave     bus
);
    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TryW = 4;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [RND_W-1:0] cur_lim_q, cur_lim_d;
    logic [TryW-1:0]  try_cnt_q, try_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [RND_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_fb_q, rsp_fb_d;
    logic             busy_q, busy_d;

    logic             pick_any;
    logic [IdxW-1:0]  pick_idx;
    logic [RND_W-1:0] pick_lim;
    logic             req_held;
    logic             accept;
    logic             last_try;

    rand_sched_rr_pick #(
        .N_REQ (N_REQ),
        .IdxW  (IdxW)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

    assign pick_lim = bus.lim[32'(pick_idx) * RND_W +: RND_W];
    assign req_held = bus.req[idx_q];
    // A zero limit encodes the full 2^RND_W range.
    assign accept   = (cur_lim_q == '0) || (rnd_in < cur_lim_q);
    assign last_try = (try_cnt_q == TryW'(MAX_TRY - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) state_d = StSample;
            end
            StSample: begin
                if (!req_held)                state_d = StIdle;
                else if (accept || last_try)  state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        cur_lim_d   = cur_lim_q;
        try_cnt_d   = try_cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_fb_d    = 1'b0;
        rsp_valid_d = 1'b0;
        gnt_d       = '0;
        busy_d      = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    idx_d     = pick_idx;
                    rr_ptr_d  = pick_idx;
                    cur_lim_d = pick_lim;
                    try_cnt_d = '0;
                end
            end
            StSample: begin
                if (req_held) begin
                    if (accept) begin
                        rsp_data_d  = rnd_in;
                        rsp_valid_d = 1'b1;
                        gnt_d       = N_REQ'(1) << idx_q;
                    end else if (last_try) begin
                        rsp_data_d  = RND_W'(FallbackVal);
                        rsp_fb_d    = 1'b1;
                        rsp_valid_d = 1'b1;
                        gnt_d       = N_REQ'(1) << idx_q;
                    end else begin
                        try_cnt_d = try_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            rr_ptr_q    <= IdxW'(N_REQ - 1);
            cur_lim_q   <= '0;
            try_cnt_q   <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fb_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_lim_q   <= cur_lim_d;
            try_cnt_q   <= try_cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fb_q    <= rsp_fb_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_fb    = rsp_fb_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/rand_sched.md
Name: rand_sched

Overview:
- Scheduler sharing the single 5-bit free-running `random` generator between up to N_REQ game consumers (obstacle spawner, item spawner, colour picker, etc.).
- Arbitrates requests round-robin and range-limits each draw by rejection sampling against a per-request upper bound.
- Returns one value per grant, so two consumers never receive the same generator sample.
- Sits between the `random` instance (its `data` feeds rnd_in) and the game logic.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- RND_W, 5, width of a random sample; must match the generator's data width.
- MAX_TRY, 8, number of rejected samples allowed before the fallback value is used (1..15).

Ports:
- clk  in  1  system clock; the generator advances on the same clock.
- rst  in  1  synchronous, active-high reset.
- rnd_in  in  RND_W  current generator output, a new value every cycle.
- req  in  N_REQ  per-requester request level.
- lim  in  N_REQ*RND_W  per-requester exclusive upper bound; slice i is lim[i*RND_W +: RND_W]; a value of 0 means full range (2^RND_W).
- gnt  out  N_REQ  one-hot grant pulse, 1 cycle.
- rsp_valid  out  1  high for exactly the gnt cycle.
- rsp_data  out  RND_W  random value, valid while rsp_valid is high.
- rsp_fb  out  1  high with rsp_valid when the fallback value (0) was returned.
- busy  out  1  high in SAMPLE and DONE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, rsp_fb=0, busy=0, try_cnt=0, rr_ptr=N_REQ-1 (requester 0 has first priority).
- Reset asserted mid-operation aborts any draw with no grant.
- FSM states: IDLE, SAMPLE, DONE.
- IDLE:
  - If req is nonzero, choose the winner: first set bit searching upward from rr_ptr+1, wrapping modulo N_REQ.
  - Latch idx=winner and cur_lim=lim slice; set rr_ptr=winner; try_cnt=0; go to SAMPLE.
  - Otherwise stay in IDLE.
- SAMPLE (each cycle, in priority order):
  - If req[idx]=0, the requester withdrew: abort to IDLE with no gnt; rr_ptr keeps its updated value.
  - Accept if cur_lim==0 or rnd_in<cur_lim (unsigned compare): rsp_data<=rnd_in, rsp_fb<=0, go to DONE.
  - Otherwise, if try_cnt==MAX_TRY-1: rsp_data<=0, rsp_fb<=1, go to DONE.
  - Otherwise try_cnt++ and stay in SAMPLE.
- DONE:
  - gnt[idx]=1, rsp_valid=1; all outputs are registered.
  - req is ignored; next state is IDLE unconditionally.
- Handshake rules:
  - A requester holds req high until it sees gnt.
  - req must be low in the cycle after gnt. A registered requester doing "if gnt then req<=0" meets this.
  - If req is still high in that cycle, it is a new request.
- Latency:
  - From the first IDLE cycle with req high to gnt is 2 cycles when the first sample is accepted.
  - Worst case is MAX_TRY+1 cycles.
- Throughput: at most 1 grant per 3 cycles.
- Each accepted sample is a distinct generator cycle. Samples consumed during rejection are discarded.
- lim changes while SAMPLE or DONE has no effect on the current draw; it takes effect at the next arbitration.
- lim=1 always yields 0 with rsp_fb=0 as soon as rnd_in==0 appears, else the fallback.
- Arbitration width: rr_ptr is $clog2(N_REQ) bits and wraps from N_REQ-1 to 0.

Decomposition:
- Shared include rand_defs.vh contains:
  - RND_W
  - FSM state encodings: IDLE=2'd0, SAMPLE=2'd1, DONE=2'd2
  - FALLBACK_VAL=0
- Sub-module rr_pick (combinational round-robin picker):
  - Inputs: req, rr_ptr.
  - Outputs: any, winner index.
  - Implement it as a rotate, priority-encode and un-rotate.
- rand_sched holds the FSM, latches, try counter and output registers.

Test Plan:
- Single requester, accept first sample: reset, req=4'b0001, lim0=10, rnd_in=7 → gnt=0001 two cycles after req seen, rsp_data=7, rsp_fb=0, rsp_valid for 1 cycle.
- Rejection then accept: lim0=10, rnd_in sequence 25,31,12,3 → 3 rejects, then gnt with rsp_data=3, total 5 cycles from req to gnt.
- Fallback: MAX_TRY=8, lim1=4, rnd_in held at 20 → gnt=0010 after SAMPLE has run 8 cycles, rsp_data=0, rsp_fb=1.
- Round-robin fairness: req=1111 held, each requester dropping req after its gnt and re-raising it 1 cycle later, lim=0 → grant order 0,1,2,3,0,…; no requester is granted twice before all others are served.
- Withdrawal and reset: req2 dropped during SAMPLE → no gnt, return to IDLE, next winner is searched from index 3. Separately, rst pulsed during SAMPLE → all outputs 0 on the next cycle and requester 0 has first priority again.
- Full range and boundary: lim=0 with rnd_in=31 → accepted, rsp_data=31. lim=31 with rnd_in=31 → rejected; the following rnd_in=30 → accepted.
